// File: rtl/dma_apb_master.sv
// dma_apb_master: APB initiator for the dma_axi64 register file (13-bit APB space).
// Host commands are queued in a small FIFO and issued as single APB transfers, one at a time.
// APB phases advance only on clk edges where pclken is high.
// Optional feature: define DMA_APB_TIMEOUT_EN to abort ACCESS phases that wait too long on pready.
module dma_apb_master #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    // host command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [12:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // host response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    // APB initiator
    input  logic        pclken,
    output logic        psel,
    output logic        penable,
    output logic [12:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    input  logic        pready
);

    localparam int unsigned PtrW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned EntryW = 1 + 13 + 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO: extra pointer MSB separates full from empty
    // ------------------------------------------------------------------
    logic [EntryW-1:0] fifo_mem [CMD_DEPTH];
    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [EntryW-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // Full blocks a push even when the FSM pops on the same edge.
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q[PtrW-1:0]];

    // Storage array: data only, flushing is done through the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PtrW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // APB sequencer state
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [12:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        timeout;

`ifdef DMA_APB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts stalled ACCESS cycles; abort fires on the edge the count reaches TIMEOUT_CYCLES
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout   = 1'b0;
        if (pclken) begin
            if (state_q == StSetup) begin
                tmo_cnt_d = '0;
            end else if (state_q == StAccess && !pready) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                timeout   = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
            end
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    // Next-state and output decode; everything APB-side holds while pclken is low
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;

        // Response handshake runs on every clk edge, independent of pclken
        if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (pclken) begin
            unique case (state_q)
                StIdle: begin
                    // Registered rsp_valid keeps SETUP off the edge that consumes a response
                    if (!fifo_empty && !rsp_valid_q) begin
                        pop                           = 1'b1;
                        {pwrite_d, paddr_d, pwdata_d} = head;
                        psel_d                        = 1'b1;
                        state_d                       = StSetup;
                    end
                end
                StSetup: begin
                    penable_d = 1'b1;
                    state_d   = StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = pslverr;
                        rsp_rdata_d = pwrite_q ? 32'h0 : prdata;
                        state_d     = StIdle;
                    end else if (timeout) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Sequencer and APB/response registers; reset drops psel/penable immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = !fifo_empty || (state_q != StIdle) || rsp_valid_q;

endmodule
